// File: rtl/alu_serial_seq.sv
// Bit-serial AND/OR/XOR/ADD unit: one 1-bit slice, LSB first, one bit per clock.
// Define ALU_SERIAL_FLAGS_EN to add the registered cout/zero flag outputs.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       S,
  output logic             busy,
  output logic             done,
`ifdef ALU_SERIAL_FLAGS_EN
  output logic             cout,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] R
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
`ifdef ALU_SERIAL_FLAGS_EN
  logic             r_cout;
  logic             r_zero;
`endif

  logic             w_xi;
  logic             w_yi;
  logic             w_ri;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_xi   = r_x[r_cnt];
  assign w_yi   = r_y[r_cnt];
  assign w_last = (r_cnt == LAST);

  // The single 1-bit slice; carry only propagates for ADD
  always_comb begin
    w_ri = 1'b0;
    w_co = 1'b0;
    unique case (r_op)
      2'b00: w_ri = w_xi & w_yi;
      2'b01: w_ri = w_xi | w_yi;
      2'b10: w_ri = w_xi ^ w_yi;
      2'b11: begin
        w_ri = w_xi ^ w_yi ^ r_carry;
        w_co = (w_xi & w_yi) | (r_carry & (w_xi ^ w_yi));
      end
      default: w_ri = 1'b0;
    endcase
  end

  always_comb begin
    w_res_nxt        = r_res;
    w_res_nxt[r_cnt] = w_ri;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
      r_op    <= 2'b00;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_op    <= S;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_nxt;
          r_carry <= w_co;
          if (w_last) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
`ifdef ALU_SERIAL_FLAGS_EN
            r_cout  <= w_co;
            r_zero  <= (w_res_nxt == '0);
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_op    <= S;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign R    = r_res;
`ifdef ALU_SERIAL_FLAGS_EN
  assign cout = r_cout;
  assign zero = r_zero;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized + directed bench for alu_serial_seq (WIDTH=8 and WIDTH=1 instances),
// checked against a plain-arithmetic reference model.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [1:0]   S = 2'b00;
  logic         busy;
  logic         done;
  logic [W-1:0] R;

  logic         start1 = 1'b0;
  logic [0:0]   x1 = '0;
  logic [0:0]   y1 = '0;
  logic [1:0]   S1 = 2'b00;
  logic         busy1;
  logic         done1;
  logic [0:0]   R1;

`ifdef ALU_SERIAL_FLAGS_EN
  logic cout, zero, cout1, zero1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x(x), .y(y), .S(S),
    .busy(busy), .done(done),
`ifdef ALU_SERIAL_FLAGS_EN
    .cout(cout), .zero(zero),
`endif
    .R(R)
  );

  alu_serial_seq #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x(x1), .y(y1), .S(S1),
    .busy(busy1), .done(done1),
`ifdef ALU_SERIAL_FLAGS_EN
    .cout(cout1), .zero(zero1),
`endif
    .R(R1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {carry_out, result} from plain arithmetic, modulo 2^w
  function automatic logic [32:0] ref_alu(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0] op, input int w);
    logic [32:0] m;
    logic [32:0] sum;
    logic [32:0] res;
    m   = (33'd1 << w) - 33'd1;
    sum = ({1'b0, a} & m) + ({1'b0, b} & m);
    res = '0;
    case (op)
      2'b00: res = {1'b0, a & b} & m;
      2'b01: res = {1'b0, a | b} & m;
      2'b10: res = {1'b0, a ^ b} & m;
      default: res = (sum & m) | ({32'd0, sum[w]} << 32);
    endcase
    return res;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      check("busy_done_excl_w1", {31'd0, busy1 & done1}, 32'd0);
    end
  end

  // Drive at a negedge; returns at the negedge after the accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input bit hold);
    x = a;
    y = b;
    S = op;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input logic [32:0] exp, input bit hold);
    int cyc;
    int n;
    cyc = 0;
    n = 0;
    while (!done && n < W + 6) begin
      if (busy) cyc++;
      if (hold) begin
        x = W'($urandom);
        y = W'($urandom);
      end
      n++;
      @(negedge clk);
    end
    if (hold) start = 1'b0;
    check("busy_len", cyc, W);
    check("done", {31'd0, done}, 32'd1);
    check("R", {24'd0, R}, exp[31:0]);
`ifdef ALU_SERIAL_FLAGS_EN
    check("cout", {31'd0, cout}, {31'd0, exp[32]});
    check("zero", {31'd0, zero}, {31'd0, exp[7:0] == 8'd0});
`endif
  endtask

  task automatic op_once(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    start_op(a, b, op, 1'b0);
    wait_done(ref_alu(a, b, op, W), 1'b0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("R_hold", {24'd0, R}, ref_alu(a, b, op, W) & 33'hFF);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [32:0]  e;
    bit           seen;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_R", {24'd0, R}, 32'd0);
    check("rst_R_w1", {31'd0, R1}, 32'd0);
`ifdef ALU_SERIAL_FLAGS_EN
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
`endif
    // start coincident with reset is ignored
    start = 1'b1;
    @(negedge clk);
    check("start_in_rst", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    op_once(8'hF0, 8'h3C, 2'b00);
    op_once(8'hFF, 8'h01, 2'b11);
    op_once(8'h12, 8'h34, 2'b11);

    // back-to-back: new start issued in the DONE cycle
    start_op(8'hA5, 8'h5A, 2'b10, 1'b0);
    wait_done(ref_alu(8'hA5, 8'h5A, 2'b10, W), 1'b0);
    start_op(8'h0F, 8'h30, 2'b01, 1'b0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(ref_alu(8'h0F, 8'h30, 2'b01, W), 1'b0);
    @(negedge clk);
    check("b2b_pulse", {31'd0, done}, 32'd0);

    // start held high with changing operands during RUN
    start_op(8'h9C, 8'h77, 2'b11, 1'b1);
    wait_done(ref_alu(8'h9C, 8'h77, 2'b11, W), 1'b1);
    @(negedge clk);
    check("hold_one_done", {31'd0, done | busy}, 32'd0);

    // reset while bit 4 of an ADD is being processed
    start_op(8'h6B, 8'h2D, 2'b11, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_R", {24'd0, R}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      seen |= done | busy;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);

    // randomized ops, randomly back-to-back
    start_op(8'h00, 8'h00, 2'b00, 1'b0);
    wait_done(33'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        check("rnd_pulse", {31'd0, done}, 32'd0);
      end
      start_op(a, b, op, 1'b0);
      wait_done(ref_alu(a, b, op, W), 1'b0);
    end
    @(negedge clk);

    // WIDTH=1 truth table
    for (int k = 0; k < 16; k++) begin
      op = 2'(k >> 2);
      x1 = 1'(k >> 1);
      y1 = 1'(k);
      S1 = op;
      e  = ref_alu({31'd0, x1}, {31'd0, y1}, op, 1);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy", {31'd0, busy1}, 32'd1);
      @(negedge clk);
      check("w1_done", {31'd0, done1}, 32'd1);
      check("w1_R", {31'd0, R1}, {31'd0, e[0]});
`ifdef ALU_SERIAL_FLAGS_EN
      check("w1_cout", {31'd0, cout1}, {31'd0, e[32]});
`endif
      @(negedge clk);
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request to begin one operation; sampled on rising clk.
REQ-005 x  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 y  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 S  input  2  op select: 00 AND, 01 OR, 10 XOR, 11 ADD; sampled with operands.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse; R valid.
REQ-010 R  output  WIDTH  result register.

Function
REQ-011 The block SHALL evaluate the selected op bit-serially through one internal 1-bit slice (inputs x_i, y_i, S, carry; output r_i), LSB first, one bit per clock.
REQ-012 The block SHALL implement states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 SHALL latch x, y, S, clear carry and bit counter to 0, and move to RUN.
REQ-014 RUN: each edge SHALL compute bit[count], write it into R[count], update carry (ADD only; other ops keep carry 0), increment count.
REQ-015 RUN SHALL move to DONE on the edge processing bit WIDTH-1.
REQ-016 DONE: done=1 for exactly one cycle; next edge SHALL go to IDLE, or to RUN (new operands latched) if start=1.
REQ-017 Latency: start sampled at edge n -> busy=1 for cycles following edges n..n+WIDTH-1; done=1 in cycle following edge n+WIDTH.
REQ-018 start SHALL be ignored while in RUN; latched operands SHALL not change mid-operation.
REQ-019 R SHALL hold its value from DONE until the next accepted start; bits of R SHALL be overwritten as RUN progresses.
REQ-020 ADD SHALL be modulo 2^WIDTH; carry out of bit WIDTH-1 SHALL be discarded unless REQ-025 applies.
REQ-021 WIDTH=1 SHALL give one RUN cycle then DONE.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, R=0, carry=0, count=0, regardless of state, including mid-RUN; the aborted operation produces no done.
REQ-024 start sampled in the same edge as rst_n=0 SHALL be ignored.

Configuration
REQ-025 Macro ALU_SERIAL_FLAGS_EN defined: outputs cout (1 bit, final carry of ADD, 0 for other ops) and zero (1 bit, R==0) SHALL exist, registered, updated on the edge entering DONE, reset to 0, held until next accepted start.
REQ-026 Macro undefined: cout and zero ports and their logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-027 x=0xF0, y=0x3C, S=00, start 1 cycle -> busy 8 cycles, then done pulse 1 cycle, R=0x30.
REQ-028 x=0xA5, y=0x5A, S=10 -> R=0xFF; then S=01, x=0x0F, y=0x30, start in DONE cycle -> back-to-back, R=0x3F 8 cycles after.
REQ-029 x=0xFF, y=0x01, S=11 -> R=0x00; with ALU_SERIAL_FLAGS_EN cout=1, zero=1; x=0x12, y=0x34 -> R=0x46, cout=0, zero=0.
REQ-030 start=1 held every cycle during RUN with changing x/y -> result matches first-latched operands only, one done per operation.
REQ-031 rst_n=0 at bit 4 of an ADD -> next cycle IDLE, busy=0, done=0, R=0x00; no done follows.
REQ-032 All 4 ops x all 4 combinations of x_0,y_0 with WIDTH=1 -> R matches AND/OR/XOR/sum truth table.
